speech_endpoint_detector: RTL and testbench
===========================================

Name: speech_endpoint_detector

Overview:
Sits directly downstream of the moving-average smoother. It consumes the smoothed 16-bit energy stream and its 32-bit sample index, and detects speech segment boundaries using two-threshold hysteresis, an onset qualification count and a hangover count. It reports each segment's start index, end index and length to the feature-extraction and framing logic.

Parameters:
ON_THRESH, 16'd1000, unsigned level at or above which a sample counts toward speech onset
OFF_THRESH, 16'd500, unsigned level below which a sample counts toward speech offset; must be <= ON_THRESH
MIN_ON, 8, consecutive valid samples >= ON_THRESH needed to declare start; range 1..255
HANGOVER, 16, consecutive valid samples < OFF_THRESH needed to declare end; range 1..255
MAX_LEN, 32'd16000, segment length cap; used only with SEG_MAXLEN_EN

Ports:
iclk  input  1  clock
irstn  input  1  synchronous, active-low reset
idata  input  16  smoothed energy sample, unsigned
iidx  input  32  sample index of idata
ivalid  input  1  idata/iidx qualify this cycle
ospeech  output  1  high while the segment is open (states SPEECH and HANG)
ostart  output  1  one-cycle pulse: segment start declared
ostart_idx  output  32  index of the first qualifying onset sample; held until the next ostart
oend  output  1  one-cycle pulse: segment closed
oend_idx  output  32  index of the last sample >= OFF_THRESH in the segment; held until the next oend
olen  output  32  oend_idx - ostart_idx + 1, modulo 2^32; valid with oend, then held

Behaviour:
- Reset (irstn low at posedge): state goes to SILENCE; counters, candidate and last-active registers clear to 0; every output is 0.
- Reset mid-segment discards the open segment. No oend is produced.
- All outputs are registered. A sample processed at edge N drives its effects on outputs after edge N (latency 1).
- Comparisons are unsigned: on = (idata >= ON_THRESH), off = (idata < OFF_THRESH).
- Counter cnt is 8 bits. It counts consecutive qualifying valid samples, including the current one.
- FSM states: SILENCE, ONSET, SPEECH, HANG. Transitions are evaluated only when ivalid=1.
- SILENCE:
  - On on: cand_start<=iidx, cnt<=1.
  - If MIN_ON==1, go to SPEECH with ostart=1, ostart_idx<=iidx, last_active<=iidx.
  - Otherwise go to ONSET.
- ONSET:
  - On on: if cnt+1==MIN_ON, go to SPEECH with ostart=1, ostart_idx<=cand_start, last_active<=iidx. Otherwise cnt++.
  - On not on: return to SILENCE with no outputs (glitch rejected).
- SPEECH:
  - On not off: last_active<=iidx.
  - On off: cnt<=1. If HANGOVER==1, close the segment; otherwise go to HANG.
- HANG:
  - On not off: return to SPEECH, last_active<=iidx.
  - On off: if cnt+1==HANGOVER, close the segment; otherwise cnt++.
- Closing a segment: state goes to SILENCE; oend=1, oend_idx<=last_active, olen<=last_active-ostart_idx+1.
- ivalid=0: state, counters and held outputs are frozen, and ostart/oend are 0. Gaps of any length are transparent.
- ostart and oend never assert in the same cycle.
- ostart_idx and olen wrap modulo 2^32 (iidx wrap-around is legal).
- ospeech rises in the same cycle as ostart and falls in the same cycle as oend.

Optional Feature:
Macro: SEG_MAXLEN_EN.
- Defined: in SPEECH or HANG, when the valid sample gives iidx-ostart_idx+1 == MAX_LEN, the segment closes on that sample.
  - oend=1, oend_idx<=iidx, olen<=MAX_LEN.
  - Next state is SILENCE. A new onset is required after that.
  - The forced close takes priority over the HANG/SPEECH transitions in that cycle.
- Not defined: no length limit; MAX_LEN is ignored and no length comparator is built.

Test Plan:
1. Reset: irstn=0 for 2 cycles while driving idata=2000, ivalid=1 -> all outputs 0, ospeech=0 on release.
2. Glitch rejection (MIN_ON=3): idx 0,1 =1200, idx 2 =100 -> no ostart, ospeech stays 0.
3. Full segment (MIN_ON=3, HANGOVER=4): idx 10-12 =1500, 13-15 =800, 16-19 =100.
   -> ostart after idx 12 with ostart_idx=10, ospeech=1.
   -> oend after idx 19 with oend_idx=15, olen=6, ospeech=0.
4. Hangover rescue: in SPEECH, idx 30-32 =100, idx 33 =700, idx 34-37 =0 -> no oend until after idx 37; oend_idx=33.
5. ivalid gaps: rerun scenario 3 with 2 idle cycles between every sample -> identical index/length results; pulses are exactly 1 cycle, each immediately after a valid sample.
6. Mid-segment reset, then SEG_MAXLEN_EN with MAX_LEN=5:
   -> reset during SPEECH gives no oend; outputs 0.
   -> with the macro, a sustained 1500 stream from idx 100 gives ostart_idx=100 and oend after idx 104 with oend_idx=104, olen=5.

Source files
------------

// File: rtl/speech_endpoint_detector.sv
`default_nettype none
// ============================================================================
// Module   : speech_endpoint_detector
// Purpose  : Finds speech segment boundaries in a smoothed energy stream using
//            two-threshold hysteresis, an onset qualification count and a
//            hangover count. Reports start index, end index and length.
// Options  : define SEG_MAXLEN_EN to force-close segments at MAX_LEN samples.
// Revision : 1.0 - initial release
// ============================================================================
module speech_endpoint_detector #(
  parameter logic [15:0] ON_THRESH  = 16'd1000,
  parameter logic [15:0] OFF_THRESH = 16'd500,
  parameter int unsigned MIN_ON     = 8,
  parameter int unsigned HANGOVER   = 16,
  parameter logic [31:0] MAX_LEN    = 32'd16000
) (
  input  logic        iclk,
  input  logic        irstn,
  input  logic [15:0] idata,
  input  logic [31:0] iidx,
  input  logic        ivalid,
  output logic        ospeech,
  output logic        ostart,
  output logic [31:0] ostart_idx,
  output logic        oend,
  output logic [31:0] oend_idx,
  output logic [31:0] olen
);

  // Counts are 8 bits wide; both qualification limits fit in 1..255.
  localparam logic [7:0] c_min_on   = MIN_ON[7:0];
  localparam logic [7:0] c_hangover = HANGOVER[7:0];

  typedef enum logic [1:0] {
    SILENCE = 2'd0,
    ONSET   = 2'd1,
    SPEECH  = 2'd2,
    HANG    = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] cand_start_q;
  logic [31:0] last_active_q;
  logic        ospeech_q;
  logic        ostart_q;
  logic [31:0] ostart_idx_q;
  logic        oend_q;
  logic [31:0] oend_idx_q;
  logic [31:0] olen_q;

  logic        w_on;
  logic        w_off;
  logic [7:0]  w_cnt_inc;
  logic [31:0] w_cur_len;

  assign w_on      = (idata >= ON_THRESH);
  assign w_off     = (idata < OFF_THRESH);
  assign w_cnt_inc = cnt_q + 8'd1;
  // Length of the open segment if it were closed at the last active sample.
  assign w_cur_len = last_active_q - ostart_idx_q + 32'd1;

`ifdef SEG_MAXLEN_EN
  logic [31:0] w_seg_len;
  logic        w_max_hit;
  // Length the segment would have if the current sample were its last.
  assign w_seg_len = iidx - ostart_idx_q + 32'd1;
  assign w_max_hit = (w_seg_len == MAX_LEN);
`else
  logic w_unused_max_len;
  assign w_unused_max_len = ^MAX_LEN;
`endif

  // Endpoint state machine; all outputs registered, everything frozen while ivalid is low.
  always_ff @(posedge iclk) begin
    if (!irstn) begin
      state_q       <= SILENCE;
      cnt_q         <= 8'd0;
      cand_start_q  <= 32'd0;
      last_active_q <= 32'd0;
      ospeech_q     <= 1'b0;
      ostart_q      <= 1'b0;
      ostart_idx_q  <= 32'd0;
      oend_q        <= 1'b0;
      oend_idx_q    <= 32'd0;
      olen_q        <= 32'd0;
    end else begin
      ostart_q <= 1'b0;
      oend_q   <= 1'b0;
      if (ivalid) begin
        case (state_q)
          SILENCE: begin
            if (w_on) begin
              cand_start_q <= iidx;
              cnt_q        <= 8'd1;
              if (c_min_on == 8'd1) begin
                state_q       <= SPEECH;
                ospeech_q     <= 1'b1;
                ostart_q      <= 1'b1;
                ostart_idx_q  <= iidx;
                last_active_q <= iidx;
              end else begin
                state_q <= ONSET;
              end
            end
          end

          ONSET: begin
            if (w_on) begin
              if (w_cnt_inc == c_min_on) begin
                state_q       <= SPEECH;
                ospeech_q     <= 1'b1;
                ostart_q      <= 1'b1;
                ostart_idx_q  <= cand_start_q;
                last_active_q <= iidx;
              end else begin
                cnt_q <= w_cnt_inc;
              end
            end else begin
              // A short burst that never qualified is dropped silently.
              state_q <= SILENCE;
            end
          end

          SPEECH, HANG: begin
`ifdef SEG_MAXLEN_EN
            // Length cap wins over every other transition on this sample.
            if (w_max_hit) begin
              state_q    <= SILENCE;
              ospeech_q  <= 1'b0;
              oend_q     <= 1'b1;
              oend_idx_q <= iidx;
              olen_q     <= MAX_LEN;
            end else
`endif
            if (!w_off) begin
              state_q       <= SPEECH;
              last_active_q <= iidx;
            end else if (state_q == SPEECH) begin
              cnt_q <= 8'd1;
              if (c_hangover == 8'd1) begin
                state_q    <= SILENCE;
                ospeech_q  <= 1'b0;
                oend_q     <= 1'b1;
                oend_idx_q <= last_active_q;
                olen_q     <= w_cur_len;
              end else begin
                state_q <= HANG;
              end
            end else if (w_cnt_inc == c_hangover) begin
              state_q    <= SILENCE;
              ospeech_q  <= 1'b0;
              oend_q     <= 1'b1;
              oend_idx_q <= last_active_q;
              olen_q     <= w_cur_len;
            end else begin
              cnt_q <= w_cnt_inc;
            end
          end

          default: begin
            state_q <= SILENCE;
          end
        endcase
      end
    end
  end

  assign ospeech    = ospeech_q;
  assign ostart     = ostart_q;
  assign ostart_idx = ostart_idx_q;
  assign oend       = oend_q;
  assign oend_idx   = oend_idx_q;
  assign olen       = olen_q;

endmodule
`default_nettype wire

// File: tb/tb_speech_endpoint_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_speech_endpoint_detector
// Purpose  : Directed and randomized checks of speech_endpoint_detector
//            against a run-length based reference model of the endpointing
//            rules. Honours SEG_MAXLEN_EN if the build defines it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_speech_endpoint_detector;

  localparam logic [15:0] ON_THRESH  = 16'd1000;
  localparam logic [15:0] OFF_THRESH = 16'd500;
  localparam int          MIN_ON     = 3;
  localparam int          HANGOVER   = 4;
  localparam logic [31:0] MAX_LEN    = 32'd5;

  logic        iclk;
  logic        irstn;
  logic [15:0] idata;
  logic [31:0] iidx;
  logic        ivalid;
  logic        ospeech;
  logic        ostart;
  logic [31:0] ostart_idx;
  logic        oend;
  logic [31:0] oend_idx;
  logic [31:0] olen;

  int n_tests = 0;
  int n_fail  = 0;

  speech_endpoint_detector #(
    .ON_THRESH  (ON_THRESH),
    .OFF_THRESH (OFF_THRESH),
    .MIN_ON     (MIN_ON),
    .HANGOVER   (HANGOVER),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .iclk       (iclk),
    .irstn      (irstn),
    .idata      (idata),
    .iidx       (iidx),
    .ivalid     (ivalid),
    .ospeech    (ospeech),
    .ostart     (ostart),
    .ostart_idx (ostart_idx),
    .oend       (oend),
    .oend_idx   (oend_idx),
    .olen       (olen)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Reference model: segments described by runs of loud / quiet samples.
  bit          m_open;
  int          m_run_on;
  int          m_run_off;
  logic [31:0] m_first_on;
  logic [31:0] m_start;
  logic [31:0] m_last;
  logic [31:0] m_end;
  logic [31:0] m_len;
  bit          e_start;
  bit          e_end;

  function automatic void model_reset();
    m_open = 0; m_run_on = 0; m_run_off = 0;
    m_first_on = '0; m_start = '0; m_last = '0; m_end = '0; m_len = '0;
    e_start = 0; e_end = 0;
  endfunction

  function automatic void model_close(input logic [31:0] last_idx, input logic [31:0] len);
    m_open   = 0;
    m_end    = last_idx;
    m_len    = len;
    e_end    = 1;
    m_run_on = 0;
  endfunction

  function automatic void model_step(input logic [15:0] d, input logic [31:0] idx, input logic v);
    bit loud;
    bit quiet;
    bit capped;
    e_start = 0;
    e_end   = 0;
    if (!v) return;
    loud   = (d >= ON_THRESH);
    quiet  = (d < OFF_THRESH);
    capped = 0;
    if (!m_open) begin
      if (loud) begin
        if (m_run_on == 0) m_first_on = idx;
        m_run_on++;
      end else begin
        m_run_on = 0;
      end
      if (m_run_on == MIN_ON) begin
        m_open    = 1;
        m_start   = m_first_on;
        m_last    = idx;
        m_run_off = 0;
        m_run_on  = 0;
        e_start   = 1;
      end
    end else begin
`ifdef SEG_MAXLEN_EN
      if (idx - m_start + 32'd1 == MAX_LEN) begin
        model_close(idx, MAX_LEN);
        capped = 1;
      end
`endif
      if (!capped) begin
        if (!quiet) begin
          m_last    = idx;
          m_run_off = 0;
        end else begin
          m_run_off++;
          if (m_run_off == HANGOVER) model_close(m_last, m_last - m_start + 32'd1);
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, "/ospeech"},    32'(ospeech),   32'(m_open));
    check({ctx, "/ostart"},     32'(ostart),    32'(e_start));
    check({ctx, "/oend"},       32'(oend),      32'(e_end));
    check({ctx, "/ostart_idx"}, ostart_idx,     m_start);
    check({ctx, "/oend_idx"},   oend_idx,       m_end);
    check({ctx, "/olen"},       olen,           m_len);
  endtask

  task automatic step(input string ctx, input logic [15:0] d, input logic [31:0] idx, input logic v);
    idata  = d;
    iidx   = idx;
    ivalid = v;
    @(posedge iclk);
    model_step(d, idx, v);
    #1;
    check_all(ctx);
  endtask

  task automatic do_reset(input int n);
    irstn  = 1'b0;
    idata  = 16'd2000;
    ivalid = 1'b1;
    repeat (n) @(posedge iclk);
    model_reset();
    #1;
    check_all("reset");
    irstn = 1'b1;
  endtask

  function automatic logic [15:0] rand_level(input int mode);
    logic [15:0] r;
    case (mode)
      0:       r = 16'($urandom_range(0, 499));
      1:       r = 16'($urandom_range(500, 999));
      default: r = 16'($urandom_range(1000, 4000));
    endcase
    return r;
  endfunction

  // Value table for the full-segment scenario, indices 10..19.
  logic [15:0] seg3 [10];

  initial begin
    logic [31:0] ridx;
    int          mode;
    logic        v;

    seg3 = '{16'd1500, 16'd1500, 16'd1500, 16'd800, 16'd800, 16'd800,
             16'd100, 16'd100, 16'd100, 16'd100};
    irstn = 1'b0; idata = '0; iidx = '0; ivalid = 1'b0;
    model_reset();

    // Reset held with loud valid input
    do_reset(2);
    check("t1_ospeech", 32'(ospeech), 32'd0);
    check("t1_olen", olen, 32'd0);
    step("t1_release", 16'd0, 32'd0, 1'b0);
    check("t1_ospeech_release", 32'(ospeech), 32'd0);

    // Glitch rejection
    step("t2", 16'd1200, 32'd0, 1'b1);
    step("t2", 16'd1200, 32'd1, 1'b1);
    step("t2", 16'd100,  32'd2, 1'b1);
    check("t2_no_speech", 32'(ospeech), 32'd0);

    // Full segment
    for (int i = 0; i < 10; i++) begin
      step("t3", seg3[i], 32'(10 + i), 1'b1);
      if (i == 2) begin
        check("t3_ostart", 32'(ostart), 32'd1);
        check("t3_ostart_idx", ostart_idx, 32'd10);
        check("t3_ospeech", 32'(ospeech), 32'd1);
      end
`ifndef SEG_MAXLEN_EN
      if (i == 8) check("t3_no_early_end", 32'(oend), 32'd0);
      if (i == 9) begin
        check("t3_oend", 32'(oend), 32'd1);
        check("t3_oend_idx", oend_idx, 32'd15);
        check("t3_olen", olen, 32'd6);
        check("t3_ospeech_fall", 32'(ospeech), 32'd0);
      end
`endif
    end
    step("t3_idle", 16'd0, 32'd20, 1'b0);

    // Hangover rescue
    for (int i = 27; i <= 29; i++) step("t4", 16'd1500, 32'(i), 1'b1);
    for (int i = 30; i <= 32; i++) step("t4", 16'd100, 32'(i), 1'b1);
    step("t4", 16'd700, 32'd33, 1'b1);
    for (int i = 34; i <= 37; i++) begin
      step("t4", 16'd0, 32'(i), 1'b1);
`ifndef SEG_MAXLEN_EN
      if (i == 36) check("t4_no_early_end", 32'(oend), 32'd0);
`endif
    end
`ifndef SEG_MAXLEN_EN
    check("t4_oend", 32'(oend), 32'd1);
    check("t4_oend_idx", oend_idx, 32'd33);
    check("t4_olen", olen, 32'd7);
`endif

    // Full segment again with two idle cycles after every sample
    for (int i = 0; i < 10; i++) begin
      step("t5", seg3[i], 32'(10 + i), 1'b1);
      if (i == 2) check("t5_ostart_idx", ostart_idx, 32'd10);
`ifndef SEG_MAXLEN_EN
      if (i == 9) begin
        check("t5_oend_idx", oend_idx, 32'd15);
        check("t5_olen", olen, 32'd6);
      end
`endif
      step("t5_gap", 16'd3000, 32'hDEAD_BEEF, 1'b0);
      check("t5_gap_pulse", 32'(ostart | oend), 32'd0);
      step("t5_gap", 16'd0, 32'hDEAD_BEEF, 1'b0);
    end

    // Reset in the middle of an open segment
    for (int i = 60; i <= 63; i++) step("t6", 16'd1500, 32'(i), 1'b1);
    check("t6_open", 32'(ospeech), 32'd1);
    do_reset(2);
    check("t6_cleared_start_idx", ostart_idx, 32'd0);
    for (int i = 64; i <= 70; i++) step("t6_after", 16'd100, 32'(i), 1'b1);
    check("t6_no_oend", 32'(oend), 32'd0);

    // Sustained loud stream
    for (int i = 100; i <= 109; i++) begin
      step("t6_long", 16'd1500, 32'(i), 1'b1);
`ifdef SEG_MAXLEN_EN
      if (i == 104) begin
        check("t6_cap_oend", 32'(oend), 32'd1);
        check("t6_cap_start_idx", ostart_idx, 32'd100);
        check("t6_cap_oend_idx", oend_idx, 32'd104);
        check("t6_cap_olen", olen, 32'd5);
      end
`endif
    end
`ifndef SEG_MAXLEN_EN
    check("t6_still_open", 32'(ospeech), 32'd1);
    check("t6_start_idx", ostart_idx, 32'd100);
`endif
    for (int i = 110; i <= 114; i++) step("t6_close", 16'd0, 32'(i), 1'b1);

    // Randomized stream crossing the 32-bit index wrap
    ridx = 32'hFFFF_FF80;
    mode = 0;
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 3) == 0) mode = int'($urandom_range(0, 2));
      v = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 299) == 0) do_reset(1);
      step("rand", rand_level(mode), ridx, v);
      if (v) ridx = ridx + 32'd1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
